// File: rtl/systolic_array_tile.sv
// Output-stationary systolic array tile: ROWS x COLS multiply-accumulate PEs.
// Ifmap lanes enter from the left and weight lanes from the top through
// triangular skew registers. After the last input beat the array is flushed with
// zeros. The accumulator rows are then drained one row per handshake.
module systolic_array_tile #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + K_WIDTH,
    localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [K_WIDTH-1:0]        i_k_len,
    input  logic                      i_signed,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] i_ifmap,
    input  logic [COLS*DATA_WIDTH-1:0] i_weight,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [COLS*ACC_WIDTH-1:0] o_out_row,
    output logic [IDX_W-1:0]          o_out_row_idx,
    output logic                      o_out_last,
    output logic                      o_busy,
    output logic                      o_done
);

    // Cycles of zero injection needed for the last beat to reach PE(ROWS-1, COLS-1)
    localparam int FLUSH_N    = ROWS + COLS - 2;
    localparam int FLUSH_LAST = (FLUSH_N > 0) ? FLUSH_N - 1 : 0;
    localparam int FL_W       = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t               state;
    logic [K_WIDTH-1:0]   k_len_q;
    logic [K_WIDTH-1:0]   beat_cnt;
    logic                 signed_q;
    logic [FL_W-1:0]      flush_cnt;
    logic [IDX_W-1:0]     row_idx;
    logic                 done_q;

    logic                 accept;
    logic                 adv;
    logic                 clr;

    // Operand entering PE(r,c) from the left / top, and each PE's accumulator
    logic [DATA_WIDTH-1:0] a_in [ROWS][COLS];
    logic [DATA_WIDTH-1:0] b_in [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  acc  [ROWS][COLS];

    assign accept = (state == LOAD) && i_in_valid;
    assign adv    = accept || (state == FLUSH);
    assign clr    = (state == IDLE) && i_start && (i_k_len != '0);

    // Full-precision product, sign- or zero-extended to the accumulator width
    function automatic logic [ACC_WIDTH-1:0] mac_product(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic                  sgn
    );
        logic signed [2*DATA_WIDTH-1:0] a_s;
        logic signed [2*DATA_WIDTH-1:0] b_s;
        logic signed [2*DATA_WIDTH-1:0] prod_s;
        logic        [2*DATA_WIDTH-1:0] a_u;
        logic        [2*DATA_WIDTH-1:0] b_u;
        logic        [2*DATA_WIDTH-1:0] prod_u;
        logic signed [ACC_WIDTH-1:0]    ext_s;
        a_s    = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        b_s    = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        a_u    = {{DATA_WIDTH{1'b0}}, a};
        b_u    = {{DATA_WIDTH{1'b0}}, b};
        prod_s = a_s * b_s;
        prod_u = a_u * b_u;
        ext_s  = ACC_WIDTH'(prod_s);
        if (sgn) begin
            return ext_s;
        end
        return ACC_WIDTH'(prod_u);
    endfunction

    // Tile sequencer: load beats, flush the skew, then drain rows
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            k_len_q   <= '0;
            signed_q  <= 1'b0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        state    <= LOAD;
                        k_len_q  <= i_k_len;
                        signed_q <= i_signed;
                        beat_cnt <= '0;
                        row_idx  <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (beat_cnt == k_len_q - K_WIDTH'(1)) begin
                            state     <= (FLUSH_N == 0) ? DRAIN : FLUSH;
                            flush_cnt <= '0;
                            row_idx   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + K_WIDTH'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FL_W'(FLUSH_LAST)) begin
                        state <= DRAIN;
                    end else begin
                        flush_cnt <= flush_cnt + FL_W'(1);
                    end
                end
                DRAIN: begin
                    if (i_out_ready) begin
                        if (row_idx == IDX_W'(ROWS-1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            row_idx <= row_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ifmap lane r: zero outside LOAD, delayed by r skew registers
    for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
        logic [DATA_WIDTH-1:0] inj_p0;
        assign inj_p0 = (state == LOAD) ? i_ifmap[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (r == 0) begin : g_direct
            assign a_in[0][0] = inj_p0;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] sr [r];
            // Shift the lane one stage per array advance
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst || clr) begin
                    for (int j = 0; j < r; j++) sr[j] <= '0;
                end else if (adv) begin
                    sr[0] <= inj_p0;
                    for (int j = 1; j < r; j++) sr[j] <= sr[j-1];
                end
            end
            assign a_in[r][0] = sr[r-1];
        end
    end

    // Weight lane c: zero outside LOAD, delayed by c skew registers
    for (genvar c = 0; c < COLS; c++) begin : g_col_skew
        logic [DATA_WIDTH-1:0] inj_p0;
        assign inj_p0 = (state == LOAD) ? i_weight[c*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (c == 0) begin : g_direct
            assign b_in[0][0] = inj_p0;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] sr [c];
            // Shift the lane one stage per array advance
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst || clr) begin
                    for (int j = 0; j < c; j++) sr[j] <= '0;
                end else if (adv) begin
                    sr[0] <= inj_p0;
                    for (int j = 1; j < c; j++) sr[j] <= sr[j-1];
                end
            end
            assign b_in[0][c] = sr[c-1];
        end
    end

    // PE grid: accumulate locally, pass ifmap right and weight down
    for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe_col
            logic [ACC_WIDTH-1:0] acc_p1;
            // Output-stationary MAC, wraps at the accumulator width
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst || clr) begin
                    acc_p1 <= '0;
                end else if (adv) begin
                    acc_p1 <= acc_p1 + mac_product(a_in[r][c], b_in[r][c], signed_q);
                end
            end
            assign acc[r][c] = acc_p1;

            if (c < COLS-1) begin : g_a_pipe
                logic [DATA_WIDTH-1:0] a_p1;
                // Forward the ifmap operand to the PE on the right
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst || clr) begin
                        a_p1 <= '0;
                    end else if (adv) begin
                        a_p1 <= a_in[r][c];
                    end
                end
                assign a_in[r][c+1] = a_p1;
            end

            if (r < ROWS-1) begin : g_b_pipe
                logic [DATA_WIDTH-1:0] b_p1;
                // Forward the weight operand to the PE below
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst || clr) begin
                        b_p1 <= '0;
                    end else if (adv) begin
                        b_p1 <= b_in[r][c];
                    end
                end
                assign b_in[r+1][c] = b_p1;
            end
        end
    end

    // Present the selected accumulator row only while draining
    always_comb begin
        o_out_row = '0;
        if (state == DRAIN) begin
            for (int c = 0; c < COLS; c++) begin
                o_out_row[c*ACC_WIDTH +: ACC_WIDTH] = acc[row_idx][c];
            end
        end
    end

    assign o_in_ready    = (state == LOAD);
    assign o_busy        = (state != IDLE);
    assign o_out_valid   = (state == DRAIN);
    assign o_out_last    = (state == DRAIN) && (row_idx == IDX_W'(ROWS-1));
    assign o_out_row_idx = (state == DRAIN) ? row_idx : '0;
    assign o_done        = done_q;

endmodule
